mux4_rr_sched: RTL and testbench

Round-robin scheduler that shares one 4:1 mux datapath between four valid/ready requesters. It holds a grant for a bounded burst, drives the registered mux select, and routes handshakes between the granted source and a single downstream sink. The block sits in front of the team's gate-level mux4 cell: one mux4 instance per data bit, with all select lines driven by this block.

---
 rtl/mux4_sched_pkg.sv | 15 +
 rtl/mux4_rr_sched_if.sv | 26 ++
 rtl/mux4.sv | 14 +
 rtl/rr_pick4.sv | 29 ++
 rtl/mux4_rr_sched.sv | 126 ++++++++++++
 tb/tb_mux4_rr_sched.sv | 259 +++++++++++++++++++++++++
 6 files changed

// File: rtl/mux4_sched_pkg.sv
// Shared types and constants for the 4-way round-robin mux scheduler and its picker.
package mux4_sched_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int BURST_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] sel2onehot(input logic [SEL_W-1:0] s);
        return NUM_REQ'(1) << s;
    endfunction
endpackage

// File: rtl/mux4_rr_sched_if.sv
// Requester/sink handshake bundle plus the scheduler's observable grant state.
interface mux4_rr_sched_if
    import mux4_sched_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [NUM_REQ-1:0]       in_valid;
    logic [NUM_REQ*WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]       in_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_ready;
    logic [SEL_W-1:0]         sel;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, sel, grant, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, sel, grant, busy
    );
endinterface

// File: rtl/mux4.sv
// Single-bit 4:1 mux cell, sum-of-products form.
module mux4 (
    input  logic       d0_i,
    input  logic       d1_i,
    input  logic       d2_i,
    input  logic       d3_i,
    input  logic [1:0] s_i,
    output logic       y_o
);
    assign y_o = (d0_i & ~s_i[1] & ~s_i[0]) |
                 (d1_i & ~s_i[1] &  s_i[0]) |
                 (d2_i &  s_i[1] & ~s_i[0]) |
                 (d3_i &  s_i[1] &  s_i[0]);
endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first eligible index scanning last+1 .. last (mod 4).
module rr_pick4
    import mux4_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   last_i,
    input  logic [NUM_REQ-1:0] mask_i,
    output logic               found_o,
    output logic [SEL_W-1:0]   idx_o
);
    logic [NUM_REQ-1:0] eligible;
    logic [SEL_W-1:0]   cand;

    assign eligible = req_i & ~mask_i;

    // Offset NUM_REQ wraps to last itself, so it is tried last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last_i + SEL_W'(i);
            if (!found_o && eligible[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end
endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin burst scheduler sharing one mux4-per-bit datapath among four requesters.
module mux4_rr_sched
    import mux4_sched_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux4_rr_sched_if.slave   bus
);
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("mux4_rr_sched: MAX_BURST must be within 1..15");
    end

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    logic               src_valid;
    logic               xfer;
    logic               rel_burst;
    logic               rel_idle;
    logic [SEL_W-1:0]   pick_last;
    logic [NUM_REQ-1:0] pick_mask;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   mux_out;

    assign src_valid = bus.in_valid[sel_q];
    assign xfer      = (state_q == GRANT) && src_valid && bus.out_ready;
    assign rel_burst = xfer && (burst_q == BURST_LAST);
    assign rel_idle  = (state_q == GRANT) && !src_valid;

    // In GRANT the current owner is the rotation origin; an idle owner is masked out.
    assign pick_last = (state_q == GRANT) ? sel_q : last_q;
    assign pick_mask = rel_idle ? sel2onehot(sel_q) : '0;

    rr_pick4 u_pick (
        .req_i   (bus.in_valid),
        .last_i  (pick_last),
        .mask_i  (pick_mask),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            grant_q <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    grant_d = sel2onehot(pick_idx);
                    burst_d = '0;
                end
            end
            GRANT: begin
                if (rel_burst || rel_idle) begin
                    last_d  = sel_q;
                    burst_d = '0;
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        grant_d = sel2onehot(pick_idx);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (xfer) begin
                    burst_d = burst_q + BURST_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready depends only on registered state and out_ready, never on in_valid.
    always_comb begin
        bus.in_ready  = '0;
        bus.out_valid = 1'b0;
        if (state_q == GRANT) begin
            bus.out_valid       = src_valid;
            bus.in_ready[sel_q] = bus.out_ready;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q == GRANT);
    assign bus.out_data = mux_out;

    for (genvar b = 0; b < WIDTH; b++) begin : g_lane
        mux4 u_mux4 (
            .d0_i (bus.in_data[0*WIDTH + b]),
            .d1_i (bus.in_data[1*WIDTH + b]),
            .d2_i (bus.in_data[2*WIDTH + b]),
            .d3_i (bus.in_data[3*WIDTH + b]),
            .s_i  (sel_q),
            .y_o  (mux_out[b])
        );
    end
endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: MAX_BURST=4 and MAX_BURST=1 builds share stimulus,
// each tracked by a rotation/burst model, plus literal expectations per scenario.
module tb_mux4_rr_sched;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic           out_ready;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    mux4_rr_sched_if #(.WIDTH(W)) ifa ();
    mux4_rr_sched_if #(.WIDTH(W)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.out_ready = out_ready;

    mux4_rr_sched #(.WIDTH(W), .MAX_BURST(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    mux4_rr_sched #(.WIDTH(W), .MAX_BURST(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    // Model: who owns the mux, beats taken so far, and who released last.
    typedef struct {
        int owner;
        int beats;
        int last;
        int sel;
    } mstate_t;

    mstate_t ms [2];

    function automatic int pick(input int from, input logic [3:0] req, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (from + k) % 4;
            if (req[c] && c != excl) return c;
        end
        return -1;
    endfunction

    function automatic mstate_t step(input mstate_t s, input int mb, input logic rst,
                                     input logic [3:0] v, input logic rdy);
        mstate_t n;
        int p;
        n = s;
        if (!rst) begin
            n.owner = -1; n.beats = 0; n.last = 3; n.sel = 0;
        end else if (s.owner < 0) begin
            p = pick(s.last, v, -1);
            if (p >= 0) begin n.owner = p; n.sel = p; n.beats = 0; end
        end else if (!v[s.owner]) begin
            n.last = s.owner; n.beats = 0;
            p = pick(s.owner, v, s.owner);
            n.owner = p;
            if (p >= 0) n.sel = p;
        end else if (rdy) begin
            if (s.beats + 1 == mb) begin
                n.last = s.owner; n.beats = 0;
                p = pick(s.owner, v, -1);
                n.owner = p; n.sel = p;
            end else begin
                n.beats = s.beats + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ms[0] <= step(ms[0], 4, rst_n, in_valid, out_ready);
        ms[1] <= step(ms[1], 1, rst_n, in_valid, out_ready);
        if (!rst_n) started <= 1'b1;
    end

    task automatic check_one(input int k, input logic [3:0] g, input logic [1:0] s, input logic b,
                             input logic ov, input logic [7:0] od, input logic [3:0] ir);
        logic [3:0] eg, eir;
        logic [1:0] es;
        logic       eb, eov;
        logic [7:0] eod;
        eb  = ms[k].owner >= 0;
        eg  = eb ? 4'(1 << ms[k].owner) : 4'b0;
        es  = 2'(ms[k].sel);
        eov = eb ? in_valid[ms[k].owner] : 1'b0;
        eir = (eb && out_ready) ? eg : 4'b0;
        eod = in_data[ms[k].sel*W +: W];
        checks++;
        if (g !== eg || s !== es || b !== eb || ov !== eov || ir !== eir || od !== eod) begin
            errors++;
            $display("FAIL model_dut%0d t=%0t: got grant=%b sel=%0d busy=%b ov=%b ir=%b od=%h, need grant=%b sel=%0d busy=%b ov=%b ir=%b od=%h",
                     k, $time, g, s, b, ov, ir, od, eg, es, eb, eov, eir, eod);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check_one(0, ifa.grant, ifa.sel, ifa.busy, ifa.out_valid, ifa.out_data, ifa.in_ready);
            check_one(1, ifb.grant, ifb.sel, ifb.busy, ifb.out_valid, ifb.out_data, ifb.in_ready);
        end
    end

    task automatic expect_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %h, need %h", name, $time, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; in_valid = 4'b0; out_ready = 1'b1;
        tick;
        rst_n = 1'b1;
    endtask

    logic [7:0] sink [$];
    logic [7:0] c1, c2;
    logic [3:0] hs;

    initial begin
        in_valid = 4'b0; in_data = '0; out_ready = 1'b0; rst_n = 1'b0;
        tick;
        tick;
        @(negedge clk);
        expect_lit("reset_grant", 32'(ifa.grant), 32'h0);
        expect_lit("reset_sel", 32'(ifa.sel), 32'h0);
        expect_lit("reset_busy", 32'(ifa.busy), 32'h0);
        expect_lit("reset_in_ready", 32'(ifa.in_ready), 32'h0);
        expect_lit("reset_out_valid", 32'(ifa.out_valid), 32'h0);

        // Single requester 2: one-cycle latency, then continuous ownership across bursts.
        tick;
        rst_n = 1'b1; in_valid = 4'b0100; in_data = {8'h00, 8'h5A, 8'h00, 8'h00}; out_ready = 1'b1;
        @(negedge clk);
        expect_lit("single_latency_grant", 32'(ifa.grant), 32'h0);
        tick;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            expect_lit("single_grant", 32'(ifa.grant), 32'b0100);
            expect_lit("single_sel", 32'(ifa.sel), 32'd2);
            expect_lit("single_busy", 32'(ifa.busy), 32'd1);
            expect_lit("single_data", 32'(ifa.out_data), 32'h5A);
            tick;
        end

        // All four valid: 0,1,2,3,0 with four beats each and no bubbles.
        do_reset;
        in_valid = 4'b1111; in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        tick;
        for (int j = 0; j < 20; j++) begin
            int idx;
            idx = (j / 4) % 4;
            @(negedge clk);
            expect_lit("rotate_grant", 32'(ifa.grant), 32'(1 << idx));
            expect_lit("rotate_data", 32'(ifa.out_data), 32'(8'hA0 + 8'h11 * idx));
            tick;
        end

        // Backpressure on requester 1 after two beats; requester 3 waits.
        do_reset;
        in_valid = 4'b1010; in_data = {8'h3C, 8'h00, 8'h1C, 8'h00};
        tick;
        tick;
        tick;
        out_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            expect_lit("stall_grant", 32'(ifa.grant), 32'b0010);
            expect_lit("stall_sel", 32'(ifa.sel), 32'd1);
            expect_lit("stall_in_ready", 32'(ifa.in_ready), 32'h0);
            tick;
        end
        out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            expect_lit("resume_grant", 32'(ifa.grant), 32'b0010);
            tick;
        end
        @(negedge clk);
        expect_lit("resume_rotate_grant", 32'(ifa.grant), 32'b1000);
        expect_lit("resume_rotate_sel", 32'(ifa.sel), 32'd3);
        tick;

        // Early drop of requester 3 after one beat; requester 0 takes over next edge.
        do_reset;
        in_valid = 4'b1000; in_data = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        tick;
        @(negedge clk);
        expect_lit("drop_first_grant", 32'(ifa.grant), 32'b1000);
        tick;
        in_valid = 4'b0001;
        @(negedge clk);
        expect_lit("drop_release_grant", 32'(ifa.grant), 32'b1000);
        expect_lit("drop_release_ov", 32'(ifa.out_valid), 32'd0);
        tick;
        @(negedge clk);
        expect_lit("drop_new_grant", 32'(ifa.grant), 32'b0001);
        expect_lit("drop_new_data", 32'(ifa.out_data), 32'hE0);
        tick;

        // Reset during a burst to requester 2, then requester 0 wins with all valid.
        do_reset;
        in_valid = 4'b0100; in_data = {8'h00, 8'h77, 8'h00, 8'h00};
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        @(negedge clk);
        expect_lit("midrst_pre_grant", 32'(ifa.grant), 32'b0100);
        tick;
        @(negedge clk);
        expect_lit("midrst_grant", 32'(ifa.grant), 32'h0);
        expect_lit("midrst_sel", 32'(ifa.sel), 32'h0);
        expect_lit("midrst_busy", 32'(ifa.busy), 32'h0);
        expect_lit("midrst_in_ready", 32'(ifa.in_ready), 32'h0);
        tick;
        rst_n = 1'b1; in_valid = 4'b1111;
        tick;
        @(negedge clk);
        expect_lit("midrst_first_winner", 32'(ifa.grant), 32'b0001);
        tick;

        // MAX_BURST=1: requesters 1 and 2 alternate every beat; sources advance on handshake.
        do_reset;
        c1 = 8'h10; c2 = 8'h20;
        in_valid = 4'b0110; in_data = {8'h00, c2, c1, 8'h00};
        sink.delete();
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (ifb.out_valid && out_ready) sink.push_back(ifb.out_data);
            hs = in_valid & ifb.in_ready;
            tick;
            if (hs[1]) c1 = c1 + 8'h1;
            if (hs[2]) c2 = c2 + 8'h1;
            in_data = {8'h00, c2, c1, 8'h00};
        end
        expect_lit("b1_beat_count", 32'(sink.size()), 32'd11);
        for (int k = 0; k < sink.size() && k < 11; k++) begin
            expect_lit("b1_beat_data", 32'(sink[k]),
                       (k % 2 == 0) ? 32'(8'h10 + k / 2) : 32'(8'h20 + k / 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
